// File: rtl/path_step_sequencer.sv
// Turns the shortest-path solver's unordered cell mask into an ordered hop stream,
// checking that the mask is one unbranched path of the reported length.
module path_step_sequencer #(
    parameter int GRID_W    = 3,
    parameter int MAX_STEPS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [8:0] path_mask,
    input  logic [3:0] source,
    input  logic [3:0] destination,
    input  logic [2:0] path_len,
    output logic       step_valid,
    input  logic       step_ready,
    output logic [3:0] step_node,
    output logic [1:0] step_dir,
    output logic       step_last,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [2:0] err_code
);

    localparam logic [3:0] ROW_STEP   = 4'(GRID_W);
    localparam logic [3:0] NODE_COUNT = 4'(GRID_W * GRID_W);
    localparam logic [3:0] LAST_ROW   = 4'(GRID_W * GRID_W - GRID_W);
    localparam logic [3:0] MAX_HOPS   = 4'(MAX_STEPS);

    localparam logic [1:0] DIR_N = 2'd0;
    localparam logic [1:0] DIR_E = 2'd1;
    localparam logic [1:0] DIR_S = 2'd2;
    localparam logic [1:0] DIR_W = 2'd3;

    localparam logic [2:0] ERR_NONE         = 3'd0;
    localparam logic [2:0] ERR_BAD_ENDPOINT = 3'd1;
    localparam logic [2:0] ERR_NO_NEXT      = 3'd2;
    localparam logic [2:0] ERR_AMBIGUOUS    = 3'd3;
    localparam logic [2:0] ERR_LEN_MISMATCH = 3'd4;
    localparam logic [2:0] ERR_UNUSED_CELLS = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_SEARCH = 3'd2,
        S_EMIT   = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    // Row-edge aware 4-neighbourhood of a node as a mask (bit n = node n).
    function automatic logic [8:0] grid_neighbours(input logic [3:0] node);
        logic [8:0] node_bit;
        logic [3:0] col;
        logic [8:0] nb;
        node_bit = 9'd1 << node;
        col      = node % ROW_STEP;
        nb       = 9'd0;
        nb = nb | ((node >= ROW_STEP)        ? (node_bit >> ROW_STEP) : 9'd0);
        nb = nb | ((node < LAST_ROW)         ? (node_bit << ROW_STEP) : 9'd0);
        nb = nb | ((col != 4'd0)             ? (node_bit >> 4'd1)     : 9'd0);
        nb = nb | ((col != ROW_STEP - 4'd1)  ? (node_bit << 4'd1)     : 9'd0);
        return nb;
    endfunction

    function automatic logic [3:0] popcount9(input logic [8:0] v);
        return {3'd0, v[0]} + {3'd0, v[1]} + {3'd0, v[2]} + {3'd0, v[3]} + {3'd0, v[4]}
             + {3'd0, v[5]} + {3'd0, v[6]} + {3'd0, v[7]} + {3'd0, v[8]};
    endfunction

    // Only meaningful when exactly one bit is set; SEARCH screens the other cases.
    function automatic logic [3:0] onehot_index(input logic [8:0] v);
        logic [3:0] idx;
        case (v)
            9'b000000001: idx = 4'd0;
            9'b000000010: idx = 4'd1;
            9'b000000100: idx = 4'd2;
            9'b000001000: idx = 4'd3;
            9'b000010000: idx = 4'd4;
            9'b000100000: idx = 4'd5;
            9'b001000000: idx = 4'd6;
            9'b010000000: idx = 4'd7;
            9'b100000000: idx = 4'd8;
            default:      idx = 4'd0;
        endcase
        return idx;
    endfunction

    function automatic logic [1:0] hop_dir(input logic [3:0] cur_node, input logic [3:0] nxt_node);
        logic [1:0] d;
        if (nxt_node == cur_node + 4'd1) begin
            d = DIR_E;
        end else if (nxt_node == cur_node + ROW_STEP) begin
            d = DIR_S;
        end else if (cur_node == nxt_node + ROW_STEP) begin
            d = DIR_N;
        end else begin
            d = DIR_W;
        end
        return d;
    endfunction

    function automatic logic mask_has(input logic [8:0] m, input logic [3:0] node);
        return (node < NODE_COUNT) && ((m & (9'd1 << node)) != 9'd0);
    endfunction

    state_t     state_r;
    logic [8:0] mask_r;
    logic [8:0] visited_r;
    logic [3:0] src_r;
    logic [3:0] dst_r;
    logic [2:0] len_r;
    logic [3:0] cur_r;
    logic [3:0] hop_cnt_r;
    logic       step_valid_r;
    logic [3:0] step_node_r;
    logic [1:0] step_dir_r;
    logic       step_last_r;
    logic       busy_r;
    logic       done_r;
    logic       error_r;
    logic [2:0] err_code_r;

    logic [8:0] mask_rev_s;
    logic [8:0] cand_s;
    logic [3:0] cand_cnt_s;
    logic [3:0] next_node_s;
    logic [1:0] next_dir_s;
    logic       endpoints_ok_s;
    logic [8:0] visited_next_s;
    logic [3:0] hop_next_s;

    // Candidate search and acceptance bookkeeping derived from the registered route state.
    always_comb begin
        mask_rev_s     = {<<{path_mask}};
        cand_s         = grid_neighbours(cur_r) & mask_r & ~visited_r;
        cand_cnt_s     = popcount9(cand_s);
        next_node_s    = onehot_index(cand_s);
        next_dir_s     = hop_dir(cur_r, next_node_s);
        endpoints_ok_s = mask_has(mask_r, src_r) && mask_has(mask_r, dst_r);
        visited_next_s = visited_r | (9'd1 << step_node_r);
        hop_next_s     = hop_cnt_r + 4'd1;
    end

    // Sequencer FSM with all handshake and status outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= S_IDLE;
            mask_r       <= 9'd0;
            visited_r    <= 9'd0;
            src_r        <= 4'd0;
            dst_r        <= 4'd0;
            len_r        <= 3'd0;
            cur_r        <= 4'd0;
            hop_cnt_r    <= 4'd0;
            step_valid_r <= 1'b0;
            step_node_r  <= 4'd0;
            step_dir_r   <= 2'd0;
            step_last_r  <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
            err_code_r   <= ERR_NONE;
        end else begin
            done_r  <= 1'b0;
            error_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        mask_r     <= mask_rev_s;
                        src_r      <= source;
                        dst_r      <= destination;
                        len_r      <= path_len;
                        visited_r  <= 9'd0;
                        hop_cnt_r  <= 4'd0;
                        err_code_r <= ERR_NONE;
                        busy_r     <= 1'b1;
                        state_r    <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (!endpoints_ok_s) begin
                        err_code_r <= ERR_BAD_ENDPOINT;
                        error_r    <= 1'b1;
                        state_r    <= S_ERR;
                    end else if (src_r == dst_r) begin
                        if (mask_r != (9'd1 << src_r)) begin
                            err_code_r <= ERR_UNUSED_CELLS;
                            error_r    <= 1'b1;
                            state_r    <= S_ERR;
                        end else if (len_r != 3'd0) begin
                            err_code_r <= ERR_LEN_MISMATCH;
                            error_r    <= 1'b1;
                            state_r    <= S_ERR;
                        end else begin
                            done_r  <= 1'b1;
                            state_r <= S_DONE;
                        end
                    end else begin
                        cur_r     <= src_r;
                        visited_r <= 9'd1 << src_r;
                        state_r   <= S_SEARCH;
                    end
                end
                S_SEARCH: begin
                    if (cand_cnt_s == 4'd0) begin
                        err_code_r <= ERR_NO_NEXT;
                        error_r    <= 1'b1;
                        state_r    <= S_ERR;
                    end else if (cand_cnt_s > 4'd1) begin
                        err_code_r <= ERR_AMBIGUOUS;
                        error_r    <= 1'b1;
                        state_r    <= S_ERR;
                    end else begin
                        step_node_r  <= next_node_s;
                        step_dir_r   <= next_dir_s;
                        step_last_r  <= (next_node_s == dst_r);
                        step_valid_r <= 1'b1;
                        state_r      <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    // Hop fields stay frozen until the consumer takes them.
                    if (step_ready) begin
                        step_valid_r <= 1'b0;
                        step_node_r  <= 4'd0;
                        step_dir_r   <= 2'd0;
                        step_last_r  <= 1'b0;
                        cur_r        <= step_node_r;
                        visited_r    <= visited_next_s;
                        hop_cnt_r    <= hop_next_s;
                        if (hop_next_s > MAX_HOPS) begin
                            err_code_r <= ERR_NO_NEXT;
                            error_r    <= 1'b1;
                            state_r    <= S_ERR;
                        end else if (step_last_r) begin
                            if (visited_next_s != mask_r) begin
                                err_code_r <= ERR_UNUSED_CELLS;
                                error_r    <= 1'b1;
                                state_r    <= S_ERR;
                            end else if (hop_next_s != {1'b0, len_r}) begin
                                err_code_r <= ERR_LEN_MISMATCH;
                                error_r    <= 1'b1;
                                state_r    <= S_ERR;
                            end else begin
                                done_r  <= 1'b1;
                                state_r <= S_DONE;
                            end
                        end else begin
                            state_r <= S_SEARCH;
                        end
                    end
                end
                S_DONE: begin
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
                S_ERR: begin
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    step_valid_r <= 1'b0;
                    busy_r       <= 1'b0;
                    state_r      <= S_IDLE;
                end
            endcase
        end
    end

    assign step_valid = step_valid_r;
    assign step_node  = step_node_r;
    assign step_dir   = step_dir_r;
    assign step_last  = step_last_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign error      = error_r;
    assign err_code   = err_code_r;

endmodule

// File: tb/tb_path_step_sequencer.sv
// Scoreboard bench for path_step_sequencer: a grid-walk reference model queues the
// expected hops and completion event, an independent monitor checks what the DUT emits.
module tb_path_step_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [8:0] path_mask;
    logic [3:0] source;
    logic [3:0] destination;
    logic [2:0] path_len;
    logic       step_valid;
    logic       step_ready;
    logic [3:0] step_node;
    logic [1:0] step_dir;
    logic       step_last;
    logic       busy;
    logic       done;
    logic       error;
    logic [2:0] err_code;

    path_step_sequencer #(.GRID_W(3), .MAX_STEPS(8)) dut (
        .clk(clk), .reset(reset), .start(start), .path_mask(path_mask),
        .source(source), .destination(destination), .path_len(path_len),
        .step_valid(step_valid), .step_ready(step_ready), .step_node(step_node),
        .step_dir(step_dir), .step_last(step_last), .busy(busy), .done(done),
        .error(error), .err_code(err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;   // 0 hop, 1 done, 2 error
        int node;
        int dir;
        int last;
        int code;
    } ev_t;

    ev_t  exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   rdy_mode = 0;      // 0 tied high, 1 random, 2 manual_rdy
    logic manual_rdy = 1'b1;

    function automatic void check(string name, int act, int expv);
        n_total++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, expv);
    endfunction

    function automatic void push_ev(int kind, int node, int dir, int last, int code);
        ev_t e;
        e.kind = kind; e.node = node; e.dir = dir; e.last = last; e.code = code;
        exp_q.push_back(e);
    endfunction

    function automatic bit adjacent(int a, int b);
        int dr, dc;
        dr = a / 3 - b / 3;
        dc = a % 3 - b % 3;
        return (dr * dr + dc * dc) == 1;
    endfunction

    function automatic int compass(int a, int b);
        int dr;
        dr = b / 3 - a / 3;
        if (dr < 0) return 0;
        if (dr > 0) return 2;
        if (b > a) return 1;
        return 3;
    endfunction

    // Reference walk over the cell set; queues every hop plus the final done/error event.
    task automatic model_route(input logic [8:0] pm, input int src, input int dst, input int len,
                               output int code, output int first_k);
        int m[9];
        int vis[9];
        int cur, nc, nx, hops, cnt;
        bit fin;
        cnt = 0;
        for (int n = 0; n < 9; n++) begin
            m[n]   = int'((pm >> (8 - n)) & 9'd1);
            vis[n] = 0;
            cnt   += m[n];
        end
        code    = 0;
        first_k = 3;
        if (src > 8 || dst > 8 || m[src] == 0 || m[dst] == 0) begin
            first_k = 2;
            code    = 1;
        end else if (src == dst) begin
            first_k = 2;
            if (cnt != 1) code = 5;
            else if (len != 0) code = 4;
        end else begin
            cur = src; vis[src] = 1; hops = 0; fin = 0;
            for (int it = 0; it < 12 && !fin; it++) begin
                nc = 0; nx = 0;
                for (int n = 0; n < 9; n++)
                    if (m[n] == 1 && vis[n] == 0 && adjacent(cur, n)) begin nc++; nx = n; end
                if (nc == 0) begin
                    code = 2; fin = 1;
                end else if (nc > 1) begin
                    code = 3; fin = 1;
                end else begin
                    push_ev(0, nx, compass(cur, nx), (nx == dst) ? 1 : 0, 0);
                    hops++;
                    vis[nx] = 1;
                    if (hops > 8) begin
                        code = 2; fin = 1;
                    end else if (nx == dst) begin
                        fin = 1;
                        for (int n = 0; n < 9; n++) if (m[n] != vis[n]) code = 5;
                        if (code == 0 && hops != len) code = 4;
                    end else begin
                        cur = nx;
                    end
                end
            end
        end
        if (code == 0) push_ev(1, 0, 0, 0, 0);
        else push_ev(2, 0, 0, 0, code);
    endtask

    // step_ready changes just after each rising edge, so the monitor sees it settled.
    initial begin
        step_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: step_ready = 1'b1;
                1: step_ready = ($urandom_range(0, 2) != 0);
                default: step_ready = manual_rdy;
            endcase
        end
    end

    ev_t mon_e;
    int  mon_kind;

    // Monitor: every accepted hop and every done/error pulse is matched against the queue.
    always @(negedge clk) begin
        if (!reset) begin
            if (step_valid && step_ready) begin
                mon_kind = (exp_q.size() > 0) ? exp_q[0].kind : -1;
                check("hop_expected", mon_kind, 0);
                if (mon_kind == 0) begin
                    mon_e = exp_q.pop_front();
                    check("hop_node", int'(step_node), mon_e.node);
                    check("hop_dir", int'(step_dir), mon_e.dir);
                    check("hop_last", int'(step_last), mon_e.last);
                end
            end
            if (done) begin
                mon_kind = (exp_q.size() > 0) ? exp_q[0].kind : -1;
                check("done_expected", mon_kind, 1);
                if (mon_kind == 1) mon_e = exp_q.pop_front();
            end
            if (error) begin
                mon_kind = (exp_q.size() > 0) ? exp_q[0].kind : -1;
                check("error_expected", mon_kind, 2);
                if (mon_kind == 2) begin
                    mon_e = exp_q.pop_front();
                    check("error_code", int'(err_code), mon_e.code);
                end
            end
        end
    end

    task automatic launch(input logic [8:0] pm, input int src, input int dst, input int len,
                          output int code, output int first_k);
        model_route(pm, src, dst, len, code, first_k);
        @(negedge clk);
        path_mask   = pm;
        source      = 4'(src);
        destination = 4'(dst);
        path_len    = 3'(len);
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
    endtask

    task automatic finish_route(input int code, input int first_k, input bit glitch, input bit track);
        int k, seen;
        bit fin;
        k = 1; seen = 0; fin = 0;
        while (!fin && k < 300) begin
            if (seen == 0 && (step_valid || done || error)) seen = k;
            if (done || error) begin
                check("busy_during_pulse", int'(busy), 1);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                check("start_in_pulse_ignored", int'(busy), 0);
                fin = 1;
            end else begin
                if (glitch && k == 2) begin
                    start       = 1'b1;
                    path_mask   = 9'($urandom);
                    source      = 4'($urandom_range(0, 8));
                    destination = 4'($urandom_range(0, 8));
                end
                @(negedge clk);
                start = 1'b0;
                k++;
            end
        end
        if (!fin) begin
            check("route_timeout", k, 0);
            reset = 1'b1;
            exp_q.delete();
            @(negedge clk);
            reset = 1'b0;
        end
        if (track) check("first_event_cycle", seen, first_k);
        check("err_code_held", int'(err_code), code);
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic run_route(input logic [8:0] pm, input int src, input int dst, input int len,
                             input bit glitch);
        int code, first_k;
        launch(pm, src, dst, len, code, first_k);
        finish_route(code, first_k, glitch, 1'b1);
    endtask

    task automatic wait_hop(input int node);
        int k;
        k = 0;
        while (!(step_valid && int'(step_node) == node) && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("hop_reached", int'(step_node), node);
    endtask

    task automatic random_route(output logic [8:0] pm, output int src, output int dst, output int len);
        int cur, hops, steps, nx;
        int vis[9];
        int opts[$];
        if ($urandom_range(0, 1) == 1) begin
            for (int n = 0; n < 9; n++) vis[n] = 0;
            cur = $urandom_range(0, 8);
            src = cur; vis[cur] = 1;
            pm = 9'd1 << (8 - cur);
            steps = $urandom_range(0, 8);
            hops = 0;
            for (int s = 0; s < steps; s++) begin
                opts.delete();
                for (int n = 0; n < 9; n++) if (vis[n] == 0 && adjacent(cur, n)) opts.push_back(n);
                if (opts.size() > 0) begin
                    nx = opts[$urandom_range(0, opts.size() - 1)];
                    vis[nx] = 1;
                    pm = pm | (9'd1 << (8 - nx));
                    cur = nx;
                    hops++;
                end
            end
            dst = cur;
            len = hops % 8;
            if ($urandom_range(0, 4) == 0) len = $urandom_range(0, 7);
            if ($urandom_range(0, 4) == 0) pm = pm ^ (9'd1 << $urandom_range(0, 8));
        end else begin
            pm  = 9'($urandom);
            src = $urandom_range(0, 10);
            dst = $urandom_range(0, 10);
            len = $urandom_range(0, 7);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int code, first_k;
        logic [8:0] pm;
        int src, dst, len;

        reset = 1'b1; start = 1'b0; path_mask = 9'd0;
        source = 4'd0; destination = 4'd0; path_len = 3'd0;
        #12;
        check("rst_step_valid", int'(step_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_error", int'(error), 0);
        check("rst_err_code", int'(err_code), 0);
        check("rst_step_node", int'(step_node), 0);
        @(negedge clk);
        reset = 1'b0;

        // Canonical route and the test-plan corner cases, ready tied high.
        rdy_mode = 0;
        run_route(9'b111001001, 0, 8, 4, 1'b0);
        run_route(9'b000010000, 4, 4, 0, 1'b0);
        run_route(9'b100000001, 0, 8, 4, 1'b0);
        run_route(9'b111001001, 0, 8, 3, 1'b0);
        run_route(9'b111001011, 0, 8, 4, 1'b0);
        run_route(9'b111001001, 8, 0, 4, 1'b0);
        run_route(9'b111111111, 0, 8, 4, 1'b0);

        // Backpressure: hold step_ready low for three edges while hop 2 is presented.
        rdy_mode = 2; manual_rdy = 1'b1;
        launch(9'b111001001, 0, 8, 4, code, first_k);
        wait_hop(1);
        manual_rdy = 1'b0;
        @(negedge clk);
        wait_hop(2);
        for (int i = 0; i < 3; i++) begin
            check("bp_valid", int'(step_valid), 1);
            check("bp_node", int'(step_node), 2);
            check("bp_dir", int'(step_dir), 1);
            if (i < 2) @(negedge clk);
        end
        manual_rdy = 1'b1;
        finish_route(code, first_k, 1'b0, 1'b0);

        // Asynchronous reset while hop 2 waits; the route restarts cleanly from hop 1.
        launch(9'b111001001, 0, 8, 4, code, first_k);
        wait_hop(1);
        manual_rdy = 1'b0;
        @(negedge clk);
        wait_hop(2);
        #2 reset = 1'b1;
        #1;
        check("midrst_step_valid", int'(step_valid), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_err_code", int'(err_code), 0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        manual_rdy = 1'b1;
        rdy_mode = 0;
        run_route(9'b111001001, 0, 8, 4, 1'b0);

        // Randomized routes with random backpressure and ignored mid-route starts.
        rdy_mode = 1;
        for (int t = 0; t < 60; t++) begin
            random_route(pm, src, dst, len);
            run_route(pm, src, dst, len, $urandom_range(0, 3) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
